// File: rtl/mac_neuron_serial.sv
// mac_neuron_serial: time-multiplexed fully-connected neuron.
// A single signed multiply-accumulate unit walks over N_IN inputs, then the
// wide accumulator is shifted, optionally rectified and saturated to DW bits.
// Valid/ready handshakes on both sides allow chaining and back-pressure.

module mac_neuron_serial #(
    parameter int                     N_IN    = 15,
    parameter int                     DW      = 8,
    parameter int                     SHIFT   = 0,
    parameter int                     RELU    = 1,
    parameter logic [N_IN*DW-1:0]     WEIGHTS = '0,
    parameter logic signed [DW-1:0]   BIAS    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IN*DW-1:0]   a_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        y,
    output logic                 sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Accumulator wide enough that bias plus N_IN full-scale products never wrap.
    localparam int ACCW = 2*DW + $clog2(N_IN) + 1;
    localparam int IDXW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [IDXW-1:0]        IDX_LAST = IDXW'(N_IN - 1);
    localparam logic signed [ACCW-1:0] Y_MAX    = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN    = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] BIAS_EXT = {{(ACCW-DW){BIAS[DW-1]}}, BIAS};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_RES  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [N_IN*DW-1:0]      a_reg_r;
    logic signed [ACCW-1:0]  acc_r;
    logic [IDXW-1:0]         idx_r;
    logic [DW-1:0]           y_r;
    logic                    sat_r;
    logic                    out_valid_r;

    logic signed [DW-1:0]    a_el_s;
    logic signed [DW-1:0]    w_el_s;
    logic signed [2*DW-1:0]  prod_s;
    logic signed [ACCW-1:0]  prod_ext_s;
    logic signed [ACCW-1:0]  shifted_s;
    logic [DW-1:0]           y_res_s;
    logic                    sat_res_s;

    // Ready depends on state and reset only, never on in_valid.
    assign in_ready  = (state_r == ST_IDLE) && !reset;
    assign y         = y_r;
    assign sat       = sat_r;
    assign out_valid = out_valid_r;

    // Current input/weight pair and its exact product, sign-extended to the accumulator.
    always_comb begin
        a_el_s     = a_reg_r[int'(idx_r)*DW +: DW];
        w_el_s     = WEIGHTS[int'(idx_r)*DW +: DW];
        prod_s     = a_el_s * w_el_s;
        prod_ext_s = {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
    end

    // Requantise the accumulator: arithmetic shift, optional ReLU, saturating clamp.
    always_comb begin
        shifted_s = acc_r >>> SHIFT;
        y_res_s   = '0;
        sat_res_s = 1'b0;
        if ((RELU != 0) && (shifted_s[ACCW-1] == 1'b1)) begin
            y_res_s   = '0;
            sat_res_s = 1'b0;
        end else if (shifted_s > Y_MAX) begin
            y_res_s   = Y_MAX[DW-1:0];
            sat_res_s = 1'b1;
        end else if (shifted_s < Y_MIN) begin
            y_res_s   = Y_MIN[DW-1:0];
            sat_res_s = 1'b1;
        end else begin
            y_res_s   = shifted_s[DW-1:0];
            sat_res_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> MAC -> RES -> OUT sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_MAC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = ST_RES;
                end else begin
                    state_nxt_s = ST_MAC;
                end
            end
            ST_RES: begin
                state_nxt_s = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and datapath; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            a_reg_r     <= '0;
            acc_r       <= '0;
            idx_r       <= '0;
            y_r         <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg_r <= a_in;
                        acc_r   <= BIAS_EXT;
                        idx_r   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_r + prod_ext_s;
                    idx_r <= idx_r + IDXW'(1);
                end
                ST_RES: begin
                    y_r         <= y_res_s;
                    sat_r       <= sat_res_s;
                    out_valid_r <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
